// File: rtl/continuous_scheduler.sv
// Continuous-monitoring scheduler: arms the timer, requests a sensor read on expiry,
// reports the result, then holds the timer low for a guard interval before re-arming.
module continuous_scheduler #(
  parameter int GUARD_CYCLES = 2,
  parameter int READ_TIMEOUT = 50000000,
  parameter int COUNT_WIDTH  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   timer_done_i,
  input  logic                   read_done_i,
  input  logic                   read_error_i,
  output logic                   timer_activate_o,
  output logic                   read_req_o,
  output logic                   sample_valid_o,
  output logic                   error_pulse_o,
  output logic                   busy_o,
  output logic [COUNT_WIDTH-1:0] sample_count_o
);

  localparam int TW = $clog2(READ_TIMEOUT);
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(READ_TIMEOUT - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_READ, S_REPORT, S_RELEASE} state_e;

  state_e                 state_q, state_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [GW-1:0]          guard_q, guard_d;
  logic                   stop_pend_q, stop_pend_d;
  logic                   read_ok;
  logic                   timer_activate_q, timer_activate_d;
  logic                   read_req_q, read_req_d;
  logic                   sample_valid_q, sample_valid_d;
  logic                   error_pulse_q, error_pulse_d;
  logic                   busy_q, busy_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= S_IDLE;
      tmo_q            <= '0;
      guard_q          <= '0;
      stop_pend_q      <= 1'b0;
      timer_activate_q <= 1'b0;
      read_req_q       <= 1'b0;
      sample_valid_q   <= 1'b0;
      error_pulse_q    <= 1'b0;
      busy_q           <= 1'b0;
      count_q          <= '0;
    end else begin
      state_q          <= state_d;
      tmo_q            <= tmo_d;
      guard_q          <= guard_d;
      stop_pend_q      <= stop_pend_d;
      timer_activate_q <= timer_activate_d;
      read_req_q       <= read_req_d;
      sample_valid_q   <= sample_valid_d;
      error_pulse_q    <= error_pulse_d;
      busy_q           <= busy_d;
      count_q          <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tmo_d       = '0;
    guard_d     = '0;
    stop_pend_d = stop_pend_q;
    read_ok     = 1'b0;
    if (state_q != S_IDLE && stop_i) stop_pend_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (start_i && !stop_i) begin
          state_d     = S_ARM;
          stop_pend_d = 1'b0;
        end
      end
      S_ARM: begin
        if (stop_pend_q)       state_d = S_RELEASE;
        else if (timer_done_i) state_d = S_READ;
      end
      S_READ: begin
        // error beats done; done on the timeout edge still counts as a good read
        if (read_error_i) begin
          state_d = S_REPORT;
        end else if (read_done_i) begin
          state_d = S_REPORT;
          read_ok = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_REPORT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_REPORT: state_d = S_RELEASE;
      S_RELEASE: begin
        if (guard_q == GUARD_LAST) state_d = stop_pend_d ? S_IDLE : S_ARM;
        else                       guard_d = guard_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    timer_activate_d = (state_d == S_ARM) || (state_d == S_READ) || (state_d == S_REPORT);
    read_req_d       = (state_d == S_READ);
    sample_valid_d   = (state_d == S_REPORT) && read_ok;
    error_pulse_d    = (state_d == S_REPORT) && !read_ok;
    busy_d           = (state_d != S_IDLE);
    count_d          = count_q;
    if (state_q == S_IDLE && state_d == S_ARM) count_d = '0;
    else if (state_d == S_REPORT && read_ok)   count_d = count_q + 1'b1;
  end

  assign timer_activate_o = timer_activate_q;
  assign read_req_o       = read_req_q;
  assign sample_valid_o   = sample_valid_q;
  assign error_pulse_o    = error_pulse_q;
  assign busy_o           = busy_q;
  assign sample_count_o   = count_q;

endmodule

// File: tb/tb_continuous_scheduler.sv
// Bench for continuous_scheduler: cycle table with direct inputs, then model-driven sequences.
module tb_continuous_scheduler;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start_i = 1'b0, stop_i = 1'b0;
  logic       td_drv = 1'b0, rd_drv = 1'b0, re_drv = 1'b0;
  logic       use_model = 1'b0, rd_respond = 1'b0;
  logic       timer_done_i, read_done_i, read_error_i;
  logic       timer_activate_o, read_req_o, sample_valid_o, error_pulse_o, busy_o;
  logic [7:0] sample_count_o;
  logic [4:0] tcnt;
  logic [3:0] rcnt;
  int         checks = 0;
  int         errors = 0;

  always #5 clk_i = ~clk_i;

  continuous_scheduler #(.GUARD_CYCLES(2), .READ_TIMEOUT(16), .COUNT_WIDTH(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .stop_i(stop_i),
    .timer_done_i(timer_done_i), .read_done_i(read_done_i), .read_error_i(read_error_i),
    .timer_activate_o(timer_activate_o), .read_req_o(read_req_o),
    .sample_valid_o(sample_valid_o), .error_pulse_o(error_pulse_o),
    .busy_o(busy_o), .sample_count_o(sample_count_o)
  );

  // Behavioural timer: done 10 cycles after activate rises, cleared while activate is low.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                tcnt <= '0;
    else if (!timer_activate_o) tcnt <= '0;
    else if (tcnt != 5'd10)     tcnt <= tcnt + 5'd1;
  end

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)              rcnt <= '0;
    else if (!read_req_o)     rcnt <= '0;
    else if (rcnt != 4'd15)   rcnt <= rcnt + 4'd1;
  end

  assign timer_done_i = use_model ? (tcnt == 5'd10) : td_drv;
  assign read_done_i  = use_model ? (rd_respond && read_req_o && rcnt >= 4'd3) : rd_drv;
  assign read_error_i = use_model ? 1'b0 : re_drv;

  typedef struct {
    logic [4:0] in;   // start, stop, timer_done, read_done, read_error
    logic [4:0] out;  // timer_activate, read_req, sample_valid, error_pulse, busy
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(input logic [4:0] in, input logic [4:0] out, input logic [7:0] cnt);
    vec_t v;
    v.in = in; v.out = out; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return sample_valid_o;
      1:       return read_req_o;
      2:       return timer_activate_o;
      default: return !busy_o;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int budget, input string nm);
    for (int n = 0; n < budget; n++) begin
      tick();
      if (sig(which)) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: no event within %0d cycles", nm, budget);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0]  = mk(5'b00000, 5'b00000, 8'd0);
    vecs[1]  = mk(5'b11000, 5'b00000, 8'd0);
    vecs[2]  = mk(5'b10000, 5'b10001, 8'd0);
    vecs[3]  = mk(5'b00000, 5'b10001, 8'd0);
    vecs[4]  = mk(5'b00100, 5'b11001, 8'd0);
    vecs[5]  = mk(5'b00100, 5'b11001, 8'd0);
    vecs[6]  = mk(5'b00111, 5'b10011, 8'd0);
    vecs[7]  = mk(5'b00100, 5'b00001, 8'd0);
    vecs[8]  = mk(5'b00000, 5'b00001, 8'd0);
    vecs[9]  = mk(5'b00000, 5'b10001, 8'd0);
    vecs[10] = mk(5'b00100, 5'b11001, 8'd0);
    vecs[11] = mk(5'b00010, 5'b10101, 8'd1);
    vecs[12] = mk(5'b00000, 5'b00001, 8'd1);
    vecs[13] = mk(5'b01000, 5'b00001, 8'd1);
    vecs[14] = mk(5'b00000, 5'b00000, 8'd1);
    vecs[15] = mk(5'b10000, 5'b10001, 8'd0);
    vecs[16] = mk(5'b01000, 5'b10001, 8'd0);
    vecs[17] = mk(5'b00000, 5'b00001, 8'd0);
    vecs[18] = mk(5'b00000, 5'b00001, 8'd0);
    vecs[19] = mk(5'b00000, 5'b00000, 8'd0);
    vecs[20] = mk(5'b10000, 5'b10001, 8'd0);
    vecs[21] = mk(5'b00100, 5'b11001, 8'd0);
    vecs[22] = mk(5'b01000, 5'b11001, 8'd0);
    vecs[23] = mk(5'b00010, 5'b10101, 8'd1);
    vecs[24] = mk(5'b00000, 5'b00001, 8'd1);
    vecs[25] = mk(5'b00000, 5'b00001, 8'd1);
    vecs[26] = mk(5'b00000, 5'b00000, 8'd1);

    repeat (3) tick();
    chk("reset tact", timer_activate_o, 0);
    chk("reset rreq", read_req_o, 0);
    chk("reset sv", sample_valid_o, 0);
    chk("reset ep", error_pulse_o, 0);
    chk("reset busy", busy_o, 0);
    chk("reset cnt", sample_count_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    for (int i = 0; i < 27; i++) begin
      {start_i, stop_i, td_drv, rd_drv, re_drv} = vecs[i].in;
      tick();
      chk($sformatf("vec%0d tact", i), timer_activate_o, vecs[i].out[4]);
      chk($sformatf("vec%0d rreq", i), read_req_o, vecs[i].out[3]);
      chk($sformatf("vec%0d sv", i), sample_valid_o, vecs[i].out[2]);
      chk($sformatf("vec%0d ep", i), error_pulse_o, vecs[i].out[1]);
      chk($sformatf("vec%0d busy", i), busy_o, vecs[i].out[0]);
      chk($sformatf("vec%0d cnt", i), sample_count_o, vecs[i].cnt);
    end
    {start_i, stop_i, td_drv, rd_drv, re_drv} = 5'b0;

    // Two good periods with the timer/reader models; guard gap of 2 cycles.
    use_model = 1'b1;
    rd_respond = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("start busy", busy_o, 1);
    chk("start tact", timer_activate_o, 1);
    chk("start cnt clr", sample_count_o, 0);
    wait_sig(0, 100, "first sv");
    chk("period1 cnt", sample_count_o, 1);
    tick();
    chk("sv one cycle", sample_valid_o, 0);
    chk("guard tact low", timer_activate_o, 0);
    n = 1;
    for (int k = 0; k < 20 && !timer_activate_o; k++) begin
      tick();
      if (!timer_activate_o) n++;
    end
    chk("guard length", n, 2);
    chk("rearm tact", timer_activate_o, 1);
    wait_sig(0, 100, "second sv");
    chk("period2 cnt", sample_count_o, 2);

    // Reset asserted mid-READ clears outputs immediately.
    rd_respond = 1'b0;
    wait_sig(1, 100, "rreq before reset");
    tick();
    tick();
    #2 rst_ni = 1'b0;
    #1;
    chk("arst tact", timer_activate_o, 0);
    chk("arst rreq", read_req_o, 0);
    chk("arst busy", busy_o, 0);
    chk("arst cnt", sample_count_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (5) tick();
    chk("post-reset busy", busy_o, 0);
    chk("post-reset tact", timer_activate_o, 0);

    // Reader never answers: read_req high for 16 cycles then an error pulse.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_sig(1, 100, "rreq for timeout");
    n = 1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (!read_req_o) break;
      n++;
    end
    chk("timeout rreq len", n, 16);
    chk("timeout ep", error_pulse_o, 1);
    chk("timeout sv", sample_valid_o, 0);
    chk("timeout cnt", sample_count_o, 0);
    tick();
    chk("timeout ep one cycle", error_pulse_o, 0);
    chk("timeout guard tact", timer_activate_o, 0);
    wait_sig(2, 20, "rearm after timeout");

    // Run the counter through 255 and wrap to 0.
    rd_respond = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      wait_sig(0, 200, "wrap sv");
      chk($sformatf("wrap cnt%0d", i), sample_count_o, i & 255);
    end

    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    wait_sig(3, 100, "stop to idle");
    chk("stopped rreq", read_req_o, 0);
    chk("stopped tact", timer_activate_o, 0);
    chk("stopped cnt kept", sample_count_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
